output_port_scheduler: RTL

OUTPUT_PORT_SCHEDULER -- requirements
Module: output_port_scheduler

---
 rtl/output_port_scheduler.sv | 110 +++++++++++
 1 files changed

// File: rtl/output_port_scheduler.sv
// Round-robin owner arbitration for one switch output port with downstream credit tracking.
// Latency: grant registered 1 cycle after req is seen in IDLE; flit transfer is combinational.
// Backpressure: flit_ready to the owner only while credits are nonzero; ownership held until tail.
module output_port_scheduler #(
    parameter int NREQ    = 4,
    parameter int CREDITS = 8
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic [NREQ-1:0]              req,
    input  logic [NREQ-1:0]              flit_valid,
    input  logic [NREQ-1:0]              flit_tail,
    output logic [NREQ-1:0]              flit_ready,
    output logic [NREQ-1:0]              grant,
    output logic                         out_valid,
    input  logic                         credit_return,
    output logic [$clog2(CREDITS+1)-1:0] credits,
    output logic                         credit_err
);

    localparam int LW = $clog2(NREQ);
    localparam int CW = $clog2(CREDITS + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state;
    logic [LW-1:0]   last;
    logic [LW-1:0]   owner;
    logic [LW-1:0]   pick;
    logic            pick_vld;
    logic            credits_nz;
    logic            transfer;
    logic            tail_xfer;

    // grant is all-zero outside LOCKED and during reset, so ready needs no state term
    assign credits_nz = (credits != '0);
    assign flit_ready = credits_nz ? grant : '0;
    assign transfer   = |(flit_valid & flit_ready);
    assign tail_xfer  = |(flit_valid & flit_ready & flit_tail);
    assign out_valid  = transfer;

    // Round-robin search starting just after the previous owner, ending at it
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            logic [LW-1:0] idx;
            idx = LW'((int'(last) + k) % NREQ);
            if (!pick_vld && req[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
        end
    end

    // Ownership FSM: lock onto the picked requester, release after its tail flit transfers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            grant <= '0;
            owner <= '0;
            last  <= LW'(NREQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state <= LOCKED;
                        grant <= NREQ'(1) << pick;
                        owner <= pick;
                    end
                end
                LOCKED: begin
                    if (tail_xfer) begin
                        state <= IDLE;
                        grant <= '0;
                        last  <= owner;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    // Downstream credit counter; a return into a full counter is an error and is dropped
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            credits    <= CW'(CREDITS);
            credit_err <= 1'b0;
        end else begin
            case ({transfer, credit_return})
                2'b10: credits <= credits - CW'(1);
                2'b01: begin
                    if (credits == CW'(CREDITS)) begin
                        credit_err <= 1'b1;
                    end else begin
                        credits <= credits + CW'(1);
                    end
                end
                default: credits <= credits;
            endcase
        end
    end

endmodule
